// File: rtl/uart_cmd_ctrl.sv
// UART command/response controller: ASCII LED commands in, button-triggered message out.
// Define UART_CMD_ECHO_EN to echo every received byte back to the host.

module uart_rx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic       rx_ready,
  output logic [7:0] rx_data
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [1:0]    sync_q, sync_d;
  logic          busy_q, busy_d, rdy_q, rdy_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d, data_q, data_d;

  always_comb begin
    sync_d = {sync_q[0], rx};
    busy_d = busy_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    shf_d  = shf_q;
    data_d = data_q;
    rdy_d  = 1'b0;
    // Start bit is sampled at half a bit period, every later bit one period on.
    lim    = (bit_q == 4'd0) ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1);
    if (!busy_q) begin
      if (!sync_q[1]) begin
        busy_d = 1'b1;
        cnt_d  = '0;
        bit_d  = '0;
      end
    end else if (cnt_q == lim) begin
      cnt_d = '0;
      if (bit_q == 4'd0) begin
        if (sync_q[1]) busy_d = 1'b0;
        else           bit_d  = 4'd1;
      end else if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        if (sync_q[1]) begin
          rdy_d  = 1'b1;
          data_d = shf_q;
        end
      end else begin
        shf_d = {sync_q[1], shf_q[7:1]};
        bit_d = bit_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b11;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      bit_q  <= '0;
      shf_q  <= '0;
      data_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      shf_q  <= shf_d;
      data_q <= data_d;
      rdy_q  <= rdy_d;
    end
  end

  assign rx_ready = rdy_q;
  assign rx_data  = data_q;
endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shf_q, shf_d;
  logic          busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    shf_d  = shf_q;
    busy_d = busy_q;
    if (!busy_q) begin
      if (tx_start) begin
        shf_d  = {1'b1, tx_data, 1'b0};
        busy_d = 1'b1;
        cnt_d  = '0;
        bit_d  = '0;
      end
    end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
      cnt_d = '0;
      shf_d = {1'b1, shf_q[9:1]};
      if (bit_q == 4'd9) busy_d = 1'b0;
      else               bit_d  = bit_q + 4'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      shf_q  <= '1;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      shf_q  <= shf_d;
      busy_q <= busy_d;
    end
  end

  assign tx      = busy_q ? shf_q[0] : 1'b1;
  assign tx_busy = busy_q;
endmodule

module uart_cmd_ctrl #(
  parameter int           BAUDRATE        = 115200,
  parameter int           CLOCK_FREQ      = 27000000,
  parameter int           LED_W           = 6,
  parameter int           MSG_LEN         = 4,
  parameter logic [127:0] MSG             = 128'h5049_4E47,  // "PING"
  parameter int           DEBOUNCE_CYCLES = 270000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             rx,
  input  logic             button,
  output logic             tx,
  output logic [LED_W-1:0] led,
  output logic             msg_busy,
  output logic             overrun
);
  localparam int CPB = CLOCK_FREQ / BAUDRATE;
  localparam int IW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef UART_CMD_ECHO_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO, S_ECHO} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO} state_t;
`endif

  state_t           state_q, state_d;
  logic             rx_ready, tx_busy;
  logic [7:0]       rx_data, msg_byte;
  logic [1:0]       btn_sync_q, btn_sync_d;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  logic             btn_stable_q, btn_stable_d, press;
  logic [LED_W-1:0] led_q, led_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             echo_q, echo_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
`ifdef UART_CMD_ECHO_EN
  logic             echo_pend_q, echo_pend_d, overrun_q, overrun_d;
  logic [7:0]       echo_buf_q, echo_buf_d;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx),
    .rx_ready(rx_ready), .rx_data(rx_data)
  );

  uart_tx #(.CLKS_PER_BIT(CPB)) u_tx (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_start(tx_start_q),
    .tx_data(tx_data_q), .tx(tx), .tx_busy(tx_busy)
  );

  always_comb begin
    msg_byte = '0;
    for (int i = 0; i < MSG_LEN; i++)
      if (idx_q == IW'(i)) msg_byte = MSG[8*(MSG_LEN-1-i) +: 8];
  end

  always_comb begin
    btn_sync_d   = {btn_sync_q[0], button};
    db_cnt_d     = '0;
    btn_stable_d = btn_stable_q;
    press        = 1'b0;
    // Any sample equal to the stable level restarts the count.
    if (btn_sync_q[1] != btn_stable_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_stable_d = btn_sync_q[1];
        press        = ~btn_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    led_d = led_q;
    if (rx_ready) begin
      for (int i = 0; i < LED_W; i++)
        if (rx_data == 8'(48 + i)) led_d[i] = ~led_q[i];
      case (rx_data)
        8'h41: led_d = '0;
        8'h43: led_d = '1;
        8'h46: begin
          led_d    = '1;
          led_d[0] = 1'b0;
        end
        8'h47: begin
          led_d = '1;
          for (int i = 0; i < LED_W && i < 2; i++) led_d[i] = 1'b0;
        end
        default: ;
      endcase
    end

    state_d    = state_q;
    idx_d      = idx_q;
    echo_d     = echo_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
`ifdef UART_CMD_ECHO_EN
    echo_pend_d = echo_pend_q;
    echo_buf_d  = echo_buf_q;
    overrun_d   = overrun_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d = S_LOAD;
          idx_d   = '0;
          echo_d  = 1'b0;
        end
`ifdef UART_CMD_ECHO_EN
        else if (echo_pend_q) state_d = S_ECHO;
`endif
      end
      S_LOAD: if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = msg_byte;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: if (tx_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: if (!tx_busy) begin
        if (echo_q || idx_q == IW'(MSG_LEN - 1)) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
`ifdef UART_CMD_ECHO_EN
      S_ECHO: if (!tx_busy) begin
        tx_start_d  = 1'b1;
        tx_data_d   = echo_buf_q;
        echo_pend_d = 1'b0;
        echo_d      = 1'b1;
        state_d     = S_WAIT_HI;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef UART_CMD_ECHO_EN
    // Arrival is applied after the start-pulse clear, so a byte taken this cycle is not an overrun.
    if (rx_ready) begin
      echo_buf_d = rx_data;
      if (echo_pend_d) overrun_d = 1'b1;
      echo_pend_d = 1'b1;
      if (rx_data == 8'h43) overrun_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      btn_sync_q   <= 2'b11;
      db_cnt_q     <= '0;
      btn_stable_q <= 1'b1;
      led_q        <= '1;
      idx_q        <= '0;
      echo_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
`ifdef UART_CMD_ECHO_EN
      echo_pend_q  <= 1'b0;
      echo_buf_q   <= '0;
      overrun_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      btn_sync_q   <= btn_sync_d;
      db_cnt_q     <= db_cnt_d;
      btn_stable_q <= btn_stable_d;
      led_q        <= led_d;
      idx_q        <= idx_d;
      echo_q       <= echo_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
`ifdef UART_CMD_ECHO_EN
      echo_pend_q  <= echo_pend_d;
      echo_buf_q   <= echo_buf_d;
      overrun_q    <= overrun_d;
`endif
    end
  end

  assign led      = led_q;
  assign msg_busy = (state_q == S_LOAD || state_q == S_WAIT_HI || state_q == S_WAIT_LO) && !echo_q;
`ifdef UART_CMD_ECHO_EN
  assign overrun  = overrun_q;
`else
  assign overrun  = 1'b0;
`endif
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Parametrised UART command/response controller that sits between the board pins and the `uart_rx`/`uart_tx` cores.
- Decodes received ASCII command bytes into an active-low LED bank of configurable width.
- On each debounced button press, transmits a configurable multi-byte message.
- Optionally echoes every received byte back to the host.
- Replaces the single-character, fixed-LED top-level controller as the standard PC-link block.

## Interface
- `BAUDRATE`, 115200, serial bit rate passed to both UART cores
- `CLOCK_FREQ`, 27000000, `sys_clk` frequency in Hz, passed to both cores
- `LED_W`, 6, LED bank width, 1..10
- `MSG_LEN`, 4, message length in bytes, 1..16
- `MSG`, `"PING"` packed as 128 bits, right-aligned; byte 0 sent first = `MSG[8*MSG_LEN-1 -: 8]`
- `DEBOUNCE_CYCLES`, 270000, cycles the button must be stable before a level change is accepted (10 ms at 27 MHz)

Ports:
- `sys_clk` in 1: clock
- `sys_rst_n` in 1: reset, asynchronous, active-low
- `rx` in 1: serial input, to `uart_rx`
- `button` in 1: raw push-button, active-low, asynchronous
- `tx` out 1: serial output, from `uart_tx`
- `led` out `LED_W`: LED drive, active-low (1 = off)
- `msg_busy` out 1: message transmission in progress
- `overrun` out 1: sticky; set when an echo byte is overwritten, cleared by the `'C'` command or reset

## Operation
**Button path**
- 2-FF synchroniser, then debounce counter.
- Stable level updates only after `DEBOUNCE_CYCLES` consecutive equal samples.
- A press event is a stable 1→0 transition: exactly one event per press, no repeat while held.

**RX decode**
- Acts on each cycle `rx_ready` = 1:
  - `'0'`+n (0x30+n), n < `LED_W`: toggle `led[n]`
  - `'A'` (0x41): `led` = all 0 (all on)
  - `'C'` (0x43): `led` = all 1; clear `overrun`
  - `'F'` (0x46): `led` = `{1..1,0}`
  - `'G'` (0x47): `led` = `{1..1,00}`
  - all other bytes, including 0x00 and digits ≥ `LED_W`: no LED change
- RX decode never blocks and is independent of TX state.

**TX FSM** (drives `tx_start`/`tx_data` to `uart_tx`)
- IDLE:
  - press event → LOAD with byte index = 0.
  - Otherwise, if echo pending (see Configuration) → ECHO.
  - If both happen in the same cycle, the message wins; the echo stays pending.
- LOAD: wait for `tx_busy` = 0; then drive `tx_data` = current byte, `tx_start` = 1 for exactly one cycle → WAIT_HI.
- WAIT_HI: wait for `tx_busy` = 1 → WAIT_LO.
- WAIT_LO: wait for `tx_busy` = 0.
  - If index = `MSG_LEN`-1 → IDLE.
  - Else increment index → LOAD.
- ECHO: same start/WAIT_HI/WAIT_LO sequence using the echo buffer; clear pending on the start pulse; return to IDLE.
- Press events outside IDLE are dropped (no queueing).
- `msg_busy` = 1 in LOAD/WAIT_HI/WAIT_LO for message bytes only.

**Reset**
- Reset mid-message aborts the message immediately; the line returns to idle per `uart_tx`.
- The message is not resumed after reset.

## Timing
Reset values:
- `led` = all 1
- `msg_busy` = 0, `overrun` = 0
- `tx_start` = 0, `tx_data` = 0x00
- FSM = IDLE, echo pending = 0
- debounced button = 1 (released)

Latencies:
- `led` updates on the clock edge after the `rx_ready` cycle (1-cycle latency).
- Press event to first `tx_start`: 2 (sync) + `DEBOUNCE_CYCLES` + ≤2 cycles.
- `tx_start` is high for exactly one cycle per byte; never two starts without an intervening `tx_busy` high/low pair.
- Message bytes are back-to-back: next `tx_start` ≤2 cycles after `tx_busy` falls.
- Byte index width = clog2(`MSG_LEN`), minimum 1; the index never exceeds `MSG_LEN`-1.

## Configuration
Macro `UART_CMD_ECHO_EN`:
- **Defined:**
  - Every `rx_ready` byte (all values) is copied to a 1-byte echo buffer and sets echo pending.
  - If pending is already set on arrival, the buffer is overwritten and `overrun` is set.
  - The echo is sent from IDLE as described above.
- **Undefined:**
  - No echo buffer; ECHO state is absent; `overrun` is tied to 0.
  - TX carries message bytes only.

## Test plan
- Reset with `rx` idle → `led` = 6'b111111, `tx` = 1, `msg_busy` = 0, `overrun` = 0; FSM stays in IDLE.
- RX `'F'`, then `'G'`, then `'3'`, then `'3'` → `led` = 111110, 111100, 110100, 111100.
- RX `'7'` (LED_W = 6), then 0x00 → `led` unchanged; `'A'` → 000000; `'C'` → 111111.
- Button pressed with 50 µs bounce, then held 30 ms → exactly one message; the line carries 0x50 0x49 0x4E 0x47 in order; `msg_busy` is high from the first start to the last `tx_busy` fall.
- Second press during the message → ignored; exactly 4 bytes total transmitted.
- With `UART_CMD_ECHO_EN`: RX `'x'` while idle → 0x78 echoed. During a message, RX `'a'` then `'b'` → after the message only 0x62 is echoed and `overrun` = 1; `'C'` then clears `overrun`.
